// File: rtl/game_input_conditioner.sv
// N-channel switch/button conditioner: 2-FF synchroniser, debounce, stable level, rise/fall pulses.
// Optional auto-repeat of rise while held is built when GAME_INPUT_REPEAT_EN is defined.
module game_input_conditioner #(
  parameter int unsigned NUM_CH        = 13,
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned HOLD_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic                                           clk,
  input  logic                                           RESET,
  input  logic [NUM_CH-1:0]                              raw_in,
  input  logic [NUM_CH-1:0]                              en_mask,
  output logic [NUM_CH-1:0]                              level,
  output logic [NUM_CH-1:0]                              rise,
  output logic [NUM_CH-1:0]                              fall,
  output logic                                           any_rise,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rise_id
);

  localparam int unsigned IDW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CW  = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [NUM_CH-1:0] s1, s2;
  logic [CW-1:0]     cnt [NUM_CH];

`ifdef GAME_INPUT_REPEAT_EN
  localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0]     hcnt [NUM_CH];
  logic [NUM_CH-1:0] repeating;
`endif

  always_ff @(posedge clk) begin
    if (RESET) begin
      s1    <= '0;
      s2    <= '0;
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
`ifdef GAME_INPUT_REPEAT_EN
        hcnt[i] <= '0;
`endif
      end
`ifdef GAME_INPUT_REPEAT_EN
      repeating <= '0;
`endif
    end else begin
      s1 <= raw_in;
      s2 <= s1;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (!en_mask[i] || (s2[i] == level[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          level[i] <= s2[i];
          cnt[i]   <= '0;
          rise[i]  <= s2[i];
          fall[i]  <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
`ifdef GAME_INPUT_REPEAT_EN
        // Hold timer restarts on every accepted change (either direction) and is idle while low/masked;
        // the later rise assignment overrides the pulse default above.
        if (!en_mask[i] || !level[i] || ((s2[i] != level[i]) && (cnt[i] == DB_LAST))) begin
          hcnt[i]      <= '0;
          repeating[i] <= 1'b0;
        end else if (hcnt[i] == (repeating[i] ? REP_LAST : HOLD_LAST)) begin
          hcnt[i]      <= '0;
          repeating[i] <= 1'b1;
          rise[i]      <= 1'b1;
        end else begin
          hcnt[i] <= hcnt[i] + HW'(1);
        end
`endif
      end
    end
  end

  always_comb begin
    logic found;
    found   = 1'b0;
    rise_id = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rise[i] && !found) begin
        rise_id = IDW'(i);
        found   = 1'b1;
      end
    end
    any_rise = |rise;
  end

endmodule

// File: tb/tb_game_input_conditioner.sv
// Randomised scoreboard bench for game_input_conditioner (NUM_CH=4, DB_CYCLES=4, HOLD=10, REPEAT=5).
module tb_game_input_conditioner;

  localparam int NC   = 4;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic [NC-1:0] raw_in = '1;
  logic [NC-1:0] en_mask = '1;
  logic [NC-1:0] level, rise, fall;
  logic          any_rise;
  logic [1:0]    rise_id;

  always #5 clk = ~clk;

  game_input_conditioner #(
    .NUM_CH(NC), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .RESET(RESET), .raw_in(raw_in), .en_mask(en_mask),
    .level(level), .rise(rise), .fall(fall), .any_rise(any_rise), .rise_id(rise_id)
  );

  typedef struct packed {
    logic [NC-1:0] lvl;
    logic [NC-1:0] rs;
    logic [NC-1:0] fl;
    logic          any;
    logic [1:0]    id;
  } exp_t;

  typedef struct packed {
    logic [NC-1:0] en;
    logic [NC-1:0] s2;
  } hist_t;

  exp_t  expq[$];
  hist_t hist[$];
  int total = 0;
  int bad   = 0;

  logic [NC-1:0] m_s1, m_s2, m_lvl;
`ifdef GAME_INPUT_REPEAT_EN
  int held [NC];
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: a level flips when the last DB edges all saw the channel enabled with the
  // synchronised input differing from the current level.
  always @(posedge clk) begin
    exp_t e;
    bit   flip;
    e = '0;
    if (RESET) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      hist.delete();
`ifdef GAME_INPUT_REPEAT_EN
      for (int c = 0; c < NC; c++) held[c] = 0;
`endif
    end else begin
      hist.push_back(hist_t'{en: en_mask, s2: m_s2});
      if (hist.size() > DB) void'(hist.pop_front());
      for (int c = 0; c < NC; c++) begin
        flip = (hist.size() == DB);
        foreach (hist[k])
          if (!hist[k].en[c] || (hist[k].s2[c] == m_lvl[c])) flip = 0;
        if (flip) begin
          m_lvl[c] = ~m_lvl[c];
          if (m_lvl[c]) e.rs[c] = 1'b1;
          else          e.fl[c] = 1'b1;
`ifdef GAME_INPUT_REPEAT_EN
          held[c] = 0;
        end else if (!en_mask[c] || !m_lvl[c]) begin
          held[c] = 0;
        end else begin
          held[c]++;
          if (held[c] == HOLD || (held[c] > HOLD && ((held[c] - HOLD) % REP) == 0))
            e.rs[c] = 1'b1;
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
    e.lvl = m_lvl;
    e.any = |e.rs;
    for (int c = NC - 1; c >= 0; c--)
      if (e.rs[c]) e.id = 2'(c);
    expq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("level",    32'(level),    32'(e.lvl));
      chk("rise",     32'(rise),     32'(e.rs));
      chk("fall",     32'(fall),     32'(e.fl));
      chk("any_rise", 32'(any_rise), 32'(e.any));
      chk("rise_id",  32'(rise_id),  32'(e.id));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    RESET = 1'b1; raw_in = '1; en_mask = '1;
    cyc(3);
    RESET = 1'b0;
    cyc(12);
    raw_in = '0;
    cyc(10);
    // Glitch shorter than the debounce window, then a real press
    raw_in[2] = 1'b1; cyc(3);
    raw_in[2] = 1'b0; cyc(10);
    raw_in[2] = 1'b1; cyc(10);
    raw_in[1] = 1'b1; cyc(10);
    raw_in[1] = 1'b0; cyc(10);
    // Masked channel toggling, then re-enabled with a differing input
    en_mask[3] = 1'b0;
    repeat (20) begin
      raw_in[3] = 1'($urandom_range(0, 1));
      cyc(1);
    end
    raw_in[3] = 1'b1; cyc(4);
    en_mask[3] = 1'b1; cyc(10);
    raw_in = '0; cyc(10);
    raw_in[3] = 1'b1; raw_in[1] = 1'b1; cyc(10);
    raw_in = '0; cyc(10);
    // Long hold for auto-repeat, then release
    raw_in[0] = 1'b1; cyc(40);
    raw_in[0] = 1'b0; cyc(20);
    repeat (400) begin
      raw_in  = raw_in ^ NC'($urandom & $urandom);
      en_mask = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '1;
      RESET   = ($urandom_range(0, 80) == 0);
      cyc($urandom_range(1, 12));
    end
    RESET = 1'b0; en_mask = '1;
    raw_in = '1; cyc(30);
    raw_in = '0; cyc(20);
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
